// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer driving an external
// single-bit full adder. One result bit is produced per clock, LSB first,
// so a WIDTH-bit add or subtract takes WIDTH cycles. Subtraction is done
// as A + ~B + 1 by inverting B on accept and seeding the carry with 1.
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  // request channel
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic             req_sub_i,
  // response channel
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_sum_o,
  output logic             rsp_cout_o,
  output logic             rsp_ovf_o,
  output logic             rsp_zero_o,
  // external full-adder cell
  output logic             fa_a_o,
  output logic             fa_b_o,
  output logic             fa_cin_o,
  input  logic             fa_sum_i,
  input  logic             fa_cout_i
);

  // One extra bit so the counter can never wrap before reaching WIDTH-1.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_cout_q;
  logic             rsp_ovf_q;
  logic             rsp_zero_q;

  // Sum register as it will look after the current shift; on the last RUN
  // cycle this is the complete result (new MSB from the adder this cycle).
  logic [WIDTH-1:0] sum_sh_d;
  logic             last_bit;

  assign sum_sh_d = {fa_sum_i, sum_sh_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Sequencer: accept, shift one bit per cycle through the adder, then hold
  // the registered result until the consumer takes it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            a_sh_q   <= req_a_i;
            b_sh_q   <= req_sub_i ? ~req_b_i : req_b_i;
            sum_sh_q <= '0;
            carry_q  <= req_sub_i;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          sum_sh_q <= sum_sh_d;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          carry_q  <= fa_cout_i;
          cnt_q    <= cnt_q + 1'b1;
          if (last_bit) begin
            rsp_sum_q  <= sum_sh_d;
            rsp_cout_q <= fa_cout_i;
            // carry_q is still the carry into the MSB at this point
            rsp_ovf_q  <= carry_q ^ fa_cout_i;
            rsp_zero_q <= (sum_sh_d == '0);
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == DONE);

  assign rsp_sum_o  = rsp_sum_q;
  assign rsp_cout_o = rsp_cout_q;
  assign rsp_ovf_o  = rsp_ovf_q;
  assign rsp_zero_o = rsp_zero_q;

  // The adder inputs are only live while a bit is being computed.
  assign fa_a_o   = (state_q == RUN) & a_sh_q[0];
  assign fa_b_o   = (state_q == RUN) & b_sh_q[0];
  assign fa_cin_o = (state_q == RUN) & carry_q;

endmodule
